// File: rtl/audio_pkg.sv
// Shared types and command-word field helpers for the audio note path.
package audio_pkg;

  localparam int unsigned PERIOD_W_DEF = 23;
  localparam int unsigned DUR_W_DEF    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_HOLD
  } seq_state_e;

  // Period lives in the low bits of the command word.
  function automatic logic [31:0] get_period(input logic [31:0] w, input int unsigned pw);
    return w & ((32'h1 << pw) - 32'h1);
  endfunction

  // Duration lives in the top bits of the command word.
  function automatic logic [31:0] get_dur(input logic [31:0] w, input int unsigned dw);
    return w >> (32 - dw);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter with clear and freeze; pulses wrap_o on the counting terminal cycle.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic frz_i,
  output logic term_o,
  output logic wrap_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == CW'(DIV - 1));
  assign wrap_o = term_o && !clr_i && !frz_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (frz_i)  cnt_d = cnt_q;
    else if (term_o) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_sequencer.sv
// Timed note player: pops {dur, period} words from the host FIFO and drives the tone generator
// for dur ticks each, back to back; dur 0 sustains until the next word arrives.
module note_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned DUR_W    = DUR_W_DEF
) (
  input  logic                bus_clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [31:0]         fifo_dout,
  input  logic                flush,
  input  logic                pause,
  output logic [PERIOD_W-1:0] period_out,
  output logic                tone_en,
  output logic                busy,
  output logic                note_done,
  output logic [15:0]         note_count
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  seq_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [15:0]         count_q, count_d;
  logic                presc_clr, presc_frz, presc_term, presc_wrap;
  logic                last_tick;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk_i  (bus_clk),
    .rst_ni (rst_n),
    .clr_i  (presc_clr),
    .frz_i  (presc_frz),
    .term_o (presc_term),
    .wrap_o (presc_wrap)
  );

  // The final tick of a note is let through a pause so the note still ends on time.
  assign last_tick = (dur_q == DUR_W'(1)) && presc_term;
  assign presc_clr = (state_q != ST_PLAY) || flush;
  assign presc_frz = pause && !last_tick;

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    dur_d      = dur_q;
    fifo_rd_en = 1'b0;
    note_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        if (!fifo_empty && !pause) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        period_d = PERIOD_W'(get_period(fifo_dout, PERIOD_W));
        dur_d    = DUR_W'(get_dur(fifo_dout, DUR_W));
        state_d  = (DUR_W'(get_dur(fifo_dout, DUR_W)) != '0) ? ST_PLAY : ST_HOLD;
      end
      ST_PLAY: begin
        if (presc_wrap) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            note_done = 1'b1;
            state_d   = (!fifo_empty && !pause) ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!fifo_empty && !pause) begin
          note_done = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d    = ST_IDLE;
      period_d   = '0;
      fifo_rd_en = 1'b0;
      note_done  = 1'b0;
    end

    count_d = count_q + 16'(note_done);
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      dur_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      dur_q    <= dur_d;
      count_q  <= count_d;
    end
  end

  // period_q still holds the last note on the first IDLE cycle; mask it so silence is immediate.
  assign period_out = (state_q == ST_IDLE) ? '0 : period_q;
  assign tone_en    = (period_out != '0) && !pause;
  assign busy       = (state_q != ST_IDLE);
  assign note_count = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a behavioural FIFO and a per-note timeline model.
module tb_note_sequencer;

  localparam int unsigned PW   = 23;
  localparam int unsigned DW   = 9;
  localparam int unsigned DIVS = 10;

  logic          bus_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [31:0]   fifo_dout = '0;
  logic          flush = 1'b0;
  logic          pause = 1'b0;
  logic [PW-1:0] period_out;
  logic          tone_en;
  logic          busy;
  logic          note_done;
  logic [15:0]   note_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] fifo_q[$];
  int          fifo_lvl = 0;
  int          rd_bad   = 0;
  logic [31:0] seq_q[$];

  typedef struct {
    logic [31:0]   word;
    logic [PW-1:0] exp_period;
    int            exp_busy;
    int            exp_tone;
  } vec_t;

  vec_t vt[4];

  always #5 bus_clk = ~bus_clk;

  assign fifo_empty = (fifo_lvl == 0);

  always @(posedge bus_clk) begin
    if (fifo_rd_en) begin
      if (fifo_lvl == 0 || flush) rd_bad++;
      if (fifo_lvl > 0) begin
        fifo_dout <= fifo_q.pop_front();
        fifo_lvl--;
      end
    end
  end

  note_sequencer #(
    .CLK_HZ   (10_000),
    .TICK_HZ  (1000),
    .PERIOD_W (PW),
    .DUR_W    (DW)
  ) dut (
    .bus_clk    (bus_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .pause      (pause),
    .period_out (period_out),
    .tone_en    (tone_en),
    .busy       (busy),
    .note_done  (note_done),
    .note_count (note_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int unsigned d, input int unsigned p);
    return 32'((d << PW) | p);
  endfunction

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_lvl++;
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    fifo_lvl = 0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge bus_clk);
      if (!busy && fifo_lvl == 0) break;
    end
    if (k == 500) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_period(input logic [PW-1:0] p, input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge bus_clk);
      if (period_out == p && busy) break;
    end
    if (k == 20) check(nm, 32'(period_out), 32'(p));
  endtask

  // Timeline model: note i starts 2 samples after the push, each later note 2 cycles after the
  // previous one ends, and each plays dur*DIV cycles; the previous period fills the gap.
  task automatic run_seq();
    int st[$];
    int en[$];
    int t, n, end_last, rds, cur;
    logic [PW-1:0] ep;
    logic [15:0]   nc0, diff;
    logic          eb, ed;
    wait_idle();
    n = seq_q.size();
    t = 2;
    foreach (seq_q[i]) begin
      int d;
      d = int'(seq_q[i] >> PW);
      st.push_back(t);
      en.push_back(t + d * DIVS - 1);
      t = t + d * DIVS + 2;
    end
    end_last = en[n-1];
    nc0 = note_count;
    rds = 0;
    foreach (seq_q[i]) push(seq_q[i]);
    for (int s = 0; s <= end_last + 3; s++) begin
      @(negedge bus_clk);
      cur = -1;
      for (int i = 0; i < n; i++) if (st[i] <= s) cur = i;
      ep = (cur >= 0 && s <= end_last) ? PW'(seq_q[cur]) : '0;
      eb = (s <= end_last);
      ed = 1'b0;
      for (int i = 0; i < n; i++) if (en[i] == s) ed = 1'b1;
      if (fifo_rd_en) rds++;
      check("seq_cycle", {6'd0, busy, note_done, tone_en, period_out},
            {6'd0, eb, ed, (ep != '0), ep});
    end
    check("seq_pops", 32'(rds), 32'(n));
    diff = note_count - nc0;
    check("seq_note_count", 32'(diff), 32'(n));
  endtask

  initial begin
    int rd, bz, tn, dn, oth, found, play, pcyc, perr, done, herr, p500, rest, trest;
    logic [15:0] nc0, diff;

    vt[0] = '{32'h0180_1234, 23'h001234, 32, 30};
    vt[1] = '{32'h0080_0007, 23'h000007, 12, 10};
    vt[2] = '{32'h02FF_FFFF, 23'h7FFFFF, 52, 50};
    vt[3] = '{32'h0100_0000, 23'h000000, 22, 0};

    #12;
    check("reset_outputs", {period_out, tone_en, busy, note_done, fifo_rd_en},
          {PW'(0), 4'b0000});
    check("reset_count", 32'(note_count), 32'd0);
    @(negedge bus_clk);
    rst_n = 1'b1;
    rd = 0; bz = 0;
    repeat (20) begin
      @(negedge bus_clk);
      if (fifo_rd_en) rd++;
      if (busy) bz++;
    end
    check("empty_no_rd", 32'(rd), 32'd0);
    check("empty_not_busy", 32'(bz), 32'd0);

    for (int v = 0; v < 4; v++) begin
      wait_idle();
      nc0 = note_count;
      rd = 0; bz = 0; tn = 0; dn = 0; oth = 0;
      push(vt[v].word);
      for (int k = 0; k < 150; k++) begin
        @(negedge bus_clk);
        if (fifo_rd_en) rd++;
        if (busy) bz++;
        if (tone_en) tn++;
        if (note_done) dn++;
        if (period_out != '0 && period_out != vt[v].exp_period) oth++;
      end
      diff = note_count - nc0;
      check("vec_rd", 32'(rd), 32'd1);
      check("vec_busy_cycles", 32'(bz), 32'(vt[v].exp_busy));
      check("vec_tone_cycles", 32'(tn), 32'(vt[v].exp_tone));
      check("vec_done", 32'(dn), 32'd1);
      check("vec_stray_period", 32'(oth), 32'd0);
      check("vec_count", 32'(diff), 32'd1);
    end

    seq_q.delete();
    seq_q.push_back(mkw(2, 100));
    seq_q.push_back(mkw(1, 200));
    run_seq();

    for (int r = 0; r < 6; r++) begin
      int n;
      seq_q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        int unsigned d, p;
        d = $urandom_range(1, 3);
        p = ($urandom_range(0, 3) == 0) ? 0 : ($urandom & 32'h007F_FFFF);
        seq_q.push_back(mkw(d, p));
      end
      run_seq();
    end

    // Sustained note released by a rest note.
    wait_idle();
    nc0 = note_count;
    push(mkw(0, 500));
    wait_period(PW'(500), "hold_start");
    herr = 0;
    repeat (200) begin
      @(negedge bus_clk);
      if (period_out != PW'(500) || !tone_en || note_done) herr++;
    end
    check("hold_steady", 32'(herr), 32'd0);
    push(mkw(1, 0));
    #1;
    p500 = 0; rest = 0; trest = 0; dn = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge bus_clk);
      if (period_out == PW'(500)) p500++;
      if (busy && period_out == '0) begin
        rest++;
        if (tone_en) trest++;
      end
      if (note_done) dn++;
    end
    diff = note_count - nc0;
    check("hold_tail", 32'(p500), 32'd3);
    check("rest_len", 32'(rest), 32'd10);
    check("rest_silent", 32'(trest), 32'd0);
    check("hold_done", 32'(dn), 32'd2);
    check("hold_count", 32'(diff), 32'd2);

    // Pause in the middle of a 4-tick note.
    wait_idle();
    push(mkw(4, 'h55));
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge bus_clk);
      if (period_out == PW'('h55)) begin
        found = 1;
        break;
      end
    end
    check("pause_start", 32'(found), 32'd1);
    play = 0; pcyc = 0; perr = 0; done = 0;
    for (int k = 0; k < 120 && done == 0; k++) begin
      if (k > 0) begin
        @(negedge bus_clk);
        pause = (play >= 15 && pcyc < 17);
        #1;
      end
      if (pause) begin
        pcyc++;
        if (tone_en || period_out != PW'('h55) || note_done) perr++;
      end else if (busy && period_out == PW'('h55)) begin
        play++;
        if (note_done) done = 1;
      end
    end
    pause = 1'b0;
    check("pause_mute", 32'(perr), 32'd0);
    check("pause_len", 32'(pcyc), 32'd17);
    check("pause_play_cycles", 32'(play), 32'd40);
    check("pause_done", 32'(done), 32'd1);

    // Flush while fetching: no pop, idle next cycle.
    wait_idle();
    nc0 = note_count;
    push(mkw(2, 'h33));
    @(negedge bus_clk);
    flush = 1'b1;
    #1;
    check("flush_fetch_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge bus_clk);
    check("flush_fetch_idle", {31'd0, busy}, 32'd0);
    check("flush_fetch_period", 32'(period_out), 32'd0);
    // The host side drops its buffered words when the file closes.
    flush_fifo();
    flush = 1'b0;

    // Flush mid-note: silence, no completion.
    push(mkw(3, 9));
    wait_period(PW'(9), "flush_play_start");
    repeat (5) @(negedge bus_clk);
    flush = 1'b1;
    #1;
    dn = note_done ? 1 : 0;
    @(negedge bus_clk);
    flush = 1'b0;
    #1;
    check("flush_play_idle", {busy, tone_en, 7'd0, period_out}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge bus_clk);
      if (note_done) dn++;
    end
    diff = note_count - nc0;
    check("flush_no_done", 32'(dn), 32'd0);
    check("flush_count", 32'(diff), 32'd0);

    // Asynchronous reset in the middle of a note.
    push(mkw(2, 'h77));
    wait_period(PW'('h77), "reset_play_start");
    repeat (3) @(negedge bus_clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {period_out, tone_en, busy, note_done, fifo_rd_en},
          {PW'(0), 4'b0000});
    check("async_reset_count", 32'(note_count), 32'd0);
    flush_fifo();
    @(negedge bus_clk);
    rst_n = 1'b1;
    rd = 0;
    repeat (20) begin
      @(negedge bus_clk);
      if (fifo_rd_en || busy) rd++;
    end
    check("post_reset_quiet", 32'(rd), 32'd0);
    seq_q.delete();
    seq_q.push_back(mkw(1, 'h42));
    run_seq();

    check("rd_protocol", 32'(rd_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
